// File: rtl/axi_slave_write_if.sv
// AXI4 write-channel slave feeding a single-port word memory with zero-cycle write latency.
// Optional AXI_WR_SLVERR_EN: non-INCR bursts or sizes above 32 bits are answered with SLVERR.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module axi_slave_write_if #(
  parameter int MEM_AW = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`AXI_IDS_BITS-1:0]   AWID,
  input  logic [`AXI_ADDR_BITS-1:0]  AWADDR,
  input  logic [`AXI_LEN_BITS-1:0]   AWLEN,
  input  logic [`AXI_SIZE_BITS-1:0]  AWSIZE,
  input  logic [1:0]                 AWBURST,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [`AXI_DATA_BITS-1:0]  WDATA,
  input  logic [`AXI_STRB_BITS-1:0]  WSTRB,
  input  logic                       WLAST,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [7:0]                 BID,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  output logic                       mem_we,
  output logic [MEM_AW-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_bwe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [7:0]        awid_r;
  logic [MEM_AW-1:0] addr_r;
  logic [3:0]        len_r;
  logic [3:0]        beat_r;
  logic [2:0]        size_r;
  logic [1:0]        burst_r;
  logic              err_r;
  logic              err_s;
  logic              aw_hs_s;
  logic              w_hs_s;
  logic              unused_ok_s;

  assign AWREADY = (state_r == IDLE);
  assign WREADY  = (state_r == DATA);
  assign BVALID  = (state_r == RESP);

  assign aw_hs_s = AWVALID && AWREADY;
  assign w_hs_s  = WVALID && WREADY;

`ifdef AXI_WR_SLVERR_EN
  assign err_s = (AWBURST != 2'b01) || (AWSIZE > 3'b010);
`else
  assign err_s = 1'b0;
`endif

  // An errored burst still consumes its beats, it just never reaches the memory.
  assign mem_we    = w_hs_s && !err_r;
  assign mem_addr  = addr_r + {{(MEM_AW-4){1'b0}}, beat_r};
  assign mem_wdata = WDATA;
  assign mem_bwe   = WSTRB;

  assign BID   = awid_r;
  assign BRESP = (BVALID && err_r) ? 2'b10 : 2'b00;

  // WLAST plays no part in termination; latched size/burst are kept only for visibility.
  assign unused_ok_s = ^{AWADDR[`AXI_ADDR_BITS-1:MEM_AW+2], AWADDR[1:0], WLAST, size_r, burst_r};

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: burst ends on the beat whose index equals the latched length.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (AWVALID) state_s = DATA;
        else         state_s = IDLE;
      end
      DATA: begin
        if (w_hs_s && (beat_r == len_r)) state_s = RESP;
        else                             state_s = DATA;
      end
      RESP: begin
        if (BREADY) state_s = IDLE;
        else        state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Address-phase capture and beat counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      awid_r  <= 8'd0;
      addr_r  <= {MEM_AW{1'b0}};
      len_r   <= 4'd0;
      size_r  <= 3'd0;
      burst_r <= 2'd0;
      err_r   <= 1'b0;
      beat_r  <= 4'd0;
    end else if (aw_hs_s) begin
      awid_r  <= AWID;
      addr_r  <= AWADDR[MEM_AW+1:2];
      len_r   <= AWLEN;
      size_r  <= AWSIZE;
      burst_r <= AWBURST;
      err_r   <= err_s;
      beat_r  <= 4'd0;
    end else if (w_hs_s) begin
      beat_r  <= beat_r + 4'd1;
    end
  end

endmodule

// File: tb/tb_axi_slave_write_if.sv
// Scoreboard bench for axi_slave_write_if: driver pushes expected memory writes and B
// responses from a burst-level model; a negedge monitor pops and compares them.
module tb_axi_slave_write_if;

  localparam int MEM_AW = 14;
  localparam int TMO    = 60;

  logic              clk;
  logic              rst;
  logic [7:0]        AWID;
  logic [31:0]       AWADDR;
  logic [3:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [7:0]        BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_bwe;

  axi_slave_write_if #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_bwe(mem_bwe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } b_t;

  wr_t wq[$];
  b_t  bq[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference rule: a burst is rejected only when the error feature is built in.
  function automatic bit model_err(input logic [1:0] burst, input logic [2:0] size);
`ifdef AXI_WR_SLVERR_EN
    return (burst != 2'b01) || (size > 3'b010);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every write pulse and every B handshake must match the next expectation.
  logic       b_hold = 1'b0;
  logic [7:0] b_hold_id = 8'd0;
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          chk("unexpected_mem_we", 64'd1, 64'd0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(w.addr));
          chk("mem_wdata", 64'(mem_wdata), 64'(w.data));
          chk("mem_bwe", 64'(mem_bwe), 64'(w.strb));
        end
      end
      if (b_hold) begin
        chk("bvalid_stable", 64'(BVALID), 64'd1);
        chk("bid_stable", 64'(BID), 64'(b_hold_id));
      end
      if (BVALID && BREADY) begin
        if (bq.size() == 0) begin
          chk("unexpected_b", 64'd1, 64'd0);
        end else begin
          b_t b;
          b = bq.pop_front();
          chk("bid", 64'(BID), 64'(b.id));
          chk("bresp", 64'(BRESP), 64'(b.resp));
        end
      end
      b_hold    = BVALID && !BREADY;
      b_hold_id = BID;
    end else begin
      b_hold = 1'b0;
    end
  end

  // One AXI write burst; abort_at >= 0 stops after that many beats with no B phase.
  task automatic run_txn(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input int gap,
                         input int bdelay, input logic [31:0] d0, input int abort_at);
    int  cnt;
    bit  err;
    wr_t w;
    b_t  b;
    err     = model_err(burst, size);
    AWID    = id;
    AWADDR  = addr;
    AWLEN   = len;
    AWBURST = burst;
    AWSIZE  = size;
    AWVALID = 1'b1;
    WVALID  = 1'($urandom_range(0, 1));
    WDATA   = $urandom;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!AWREADY && cnt < TMO);
    if (!AWREADY) chk("aw_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == abort_at) return;
      if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        WVALID = 1'b0;
        @(posedge clk); #1;
      end
      WDATA  = (i == 0) ? d0 : $urandom;
      WSTRB  = (i == 0 && gap == 0) ? 4'hF : 4'($urandom);
      WLAST  = (i == int'(len)) ^ ($urandom_range(0, 7) == 0);
      WVALID = 1'b1;
      if (!err) begin
        w.addr = ((int'(addr) >>> 2) + i) % (1 << MEM_AW);
        w.addr = (int'(addr[31:2]) + i) % (1 << MEM_AW);
        w.data = WDATA;
        w.strb = WSTRB;
        wq.push_back(w);
      end
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!WREADY && cnt < TMO);
      if (!WREADY) chk("w_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      WVALID = 1'b0;
    end
    b.id   = id;
    b.resp = err ? 2'b10 : 2'b00;
    bq.push_back(b);
    BREADY = 1'b0;
    for (int k = 0; k < bdelay; k++) begin
      WVALID = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_bvalid", 64'(BVALID), 64'd1);
      chk("bp_awready", 64'(AWREADY), 64'd0);
      @(posedge clk); #1;
    end
    WVALID = 1'b0;
    BREADY = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!BVALID && cnt < TMO);
    if (!BVALID) chk("b_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    BREADY = 1'b0;
    @(negedge clk);
    chk("awready_after_b", 64'(AWREADY), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    AWID = 8'd0; AWADDR = 32'd0; AWLEN = 4'd0; AWSIZE = 3'd0; AWBURST = 2'd0; AWVALID = 1'b0;
    WDATA = 32'd0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b1; BREADY = 1'b1;
    @(negedge clk);
    chk("rst_awready", 64'(AWREADY), 64'd1);
    chk("rst_wready", 64'(WREADY), 64'd0);
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_bid", 64'(BID), 64'd0);
    chk("rst_bresp", 64'(BRESP), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    WVALID = 1'b0;
    BREADY = 1'b0;
    @(posedge clk); #1;

    run_txn(8'h15, 32'h0000_0010, 4'd0, 2'b01, 3'b010, 0, 0, 32'hDEAD_BEEF, -1);
    run_txn(8'h22, 32'h0000_0100, 4'd3, 2'b01, 3'b010, 1, 1, 32'h1111_2222, -1);
    run_txn(8'h33, 32'h0000_FFFC, 4'd1, 2'b01, 3'b010, 0, 0, 32'h3333_4444, -1);
    run_txn(8'h44, 32'h0000_0200, 4'd2, 2'b01, 3'b010, 0, 5, 32'h5555_6666, -1);

    // Reset after two beats of a four-beat burst: no B may ever appear for it.
    run_txn(8'h55, 32'h0000_0300, 4'd3, 2'b01, 3'b010, 0, 0, 32'h7777_8888, 2);
    rst    = 1'b0;
    WVALID = 1'b1;
    BREADY = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("midrst_awready", 64'(AWREADY), 64'd1);
      chk("midrst_bvalid", 64'(BVALID), 64'd0);
      chk("midrst_mem_we", 64'(mem_we), 64'd0);
      @(posedge clk); #1;
    end
    rst    = 1'b1;
    WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postrst_idle_bvalid", 64'(BVALID), 64'd0);
      @(posedge clk); #1;
    end
    BREADY = 1'b0;
    run_txn(8'h66, 32'h0000_0040, 4'd0, 2'b01, 3'b010, 0, 0, 32'hCAFE_F00D, -1);

    run_txn(8'h77, 32'h0000_0080, 4'd1, 2'b10, 3'b010, 0, 0, 32'hABCD_0123, -1);

    for (int t = 0; t < 40; t++) begin
      logic [1:0] bu;
      logic [2:0] sz;
      bu = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
      sz = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b010;
      run_txn(8'($urandom), $urandom, 4'($urandom), bu, sz, 2, $urandom_range(0, 3),
              $urandom, -1);
    end

    repeat (3) @(posedge clk);
    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("bq_drained", 64'(bq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_slave_write_if.md
AXI_SLAVE_WRITE_IF -- requirements
Module: axi_slave_write_if

Interface
REQ-001 SHALL have parameter MEM_AW, default 14, word-address width of the attached memory port.
REQ-002 SHALL have port clk  input  1  the single clock for all state; all state SHALL update on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports AWID  input  `AXI_IDS_BITS (8); AWADDR  input  `AXI_ADDR_BITS (32); AWLEN  input  `AXI_LEN_BITS (4); AWSIZE  input  `AXI_SIZE_BITS (3); AWBURST  input  2; AWVALID  input  1; AWREADY  output  1.
REQ-005 SHALL have ports WDATA  input  `AXI_DATA_BITS (32); WSTRB  input  `AXI_STRB_BITS (4); WLAST  input  1; WVALID  input  1; WREADY  output  1.
REQ-006 SHALL have ports BID  output  8; BRESP  output  2; BVALID  output  1; BREADY  input  1.
REQ-007 SHALL have ports mem_we  output  1  one-cycle write strobe; mem_addr  output  MEM_AW  word address; mem_wdata  output  32; mem_bwe  output  4  byte enables.

Function
REQ-008 SHALL implement FSM states IDLE, DATA and RESP; AWREADY=1 only in IDLE, WREADY=1 only in DATA, BVALID=1 only in RESP (all decoded from the state register).
REQ-009 SHALL transition IDLE->DATA on AWVALID&&AWREADY and latch AWID, AWADDR[MEM_AW+1:2], AWLEN, AWSIZE and AWBURST in that cycle.
REQ-010 SHALL hold a 4-bit beat counter, cleared on AW handshake and incremented on each W handshake (WVALID&&WREADY).
REQ-011 SHALL drive mem_we=WVALID&&WREADY combinationally; mem_wdata=WDATA and mem_bwe=WSTRB in the same cycle, giving zero-cycle write latency.
REQ-012 SHALL drive mem_addr = latched word address + beat counter, truncated to MEM_AW bits (wrap-around modulo 2^MEM_AW).
REQ-013 SHALL transition DATA->RESP on the W handshake where beat counter == latched AWLEN; the burst length SHALL be AWLEN+1 beats (1..16).
REQ-014 SHALL ignore WLAST for termination; a WLAST mismatch SHALL NOT alter the beat count or the response.
REQ-015 SHALL drive BID = latched AWID and hold BID/BRESP/BVALID stable until BREADY; RESP->IDLE on BVALID&&BREADY.
REQ-016 SHALL NOT accept a new AW before the B handshake completes; next AWREADY=1 occurs in the cycle after the B handshake.
REQ-017 SHALL drive BRESP=2'b00 (OKAY) unless REQ-022 applies.
REQ-018 SHALL keep mem_we=0 in IDLE and RESP regardless of WVALID.

Reset
REQ-019 SHALL, while rst=0, force state=IDLE, the beat counter and all latched fields to 0; AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=0, mem_we=0.
REQ-020 SHALL, on reset mid-burst or in RESP, abandon the transaction without issuing B; no further mem_we SHALL occur for it.

Configuration
REQ-021 SHALL support macro AXI_WR_SLVERR_EN.
REQ-022 With AXI_WR_SLVERR_EN defined: AWBURST!=2'b01 (INCR) or AWSIZE>3'b010 SHALL set a latched error flag; beats SHALL still be handshaked, mem_we SHALL stay 0 for the whole burst, and BRESP SHALL be 2'b10 (SLVERR).
REQ-023 Without AXI_WR_SLVERR_EN: AWBURST and AWSIZE SHALL be ignored, every burst SHALL be written as INCR word accesses, and BRESP SHALL always be OKAY.

Verification
REQ-024 Single beat: AWID=8'h15, AWADDR=32'h0000_0010, AWLEN=0; W 32'hDEAD_BEEF, WSTRB=4'hF -> mem_we one cycle, mem_addr=4, BID=8'h15, BRESP=OKAY.
REQ-025 Burst AWLEN=3 at AWADDR=32'h0000_0100, WVALID gapped every other cycle -> exactly 4 mem_we pulses at mem_addr 64,65,66,67; then BVALID.
REQ-026 Wrap: MEM_AW=14, AWADDR word 16383, AWLEN=1 -> mem_addr 16383 then 0.
REQ-027 Backpressure: BREADY low for 5 cycles -> BVALID/BID stable for 5 cycles, AWREADY=0 throughout, AWREADY=1 the cycle after BREADY.
REQ-028 Reset asserted after beat 2 of AWLEN=3 -> no B, AWREADY=1 during reset; new single-beat transaction completes normally.
REQ-029 With AXI_WR_SLVERR_EN, AWBURST=2'b10, AWLEN=1 -> two W handshakes, no mem_we, BRESP=2'b10; without macro -> two writes, BRESP=OKAY.
